// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around mem_port_arbiter.
// Handshakes: a requester holds req and its fields stable until the cycle gnt is high;
// mem_req holds with stable fields until the cycle mem_ready is high; valid is a one-cycle pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                i_req;
    logic [ADDR_W-1:0]   i_addr;
    logic                i_gnt;
    logic                i_valid;
    logic [DATA_W-1:0]   i_rdata;

    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W/8-1:0] d_be;
    logic                d_gnt;
    logic                d_valid;
    logic [DATA_W-1:0]   d_rdata;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic                mem_ready;
    logic [DATA_W-1:0]   mem_rdata;

    // Arbiter view: serves requesters and masters the memory port.
    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Environment view: requesters plus memory model.
    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is data priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_port_arbiter_if.master   bus,
    output logic [1:0]           dbg_state
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              pick_d;
    logic              i_gnt;
    logic              d_gnt;
    logic              mem_req;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              i_valid_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers whether data won the last grant; starts as data so fetch wins the first tie.
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_d <= 1'b1;
        else if (i_gnt) last_d <= 1'b0;
        else if (d_gnt) last_d <= 1'b1;
    end

    assign pick_d = bus.d_req & (~bus.i_req | ~last_d);
`else
    assign pick_d = bus.d_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_gnt)      next_state = DBUSY;
                else if (i_gnt) next_state = IBUSY;
            end
            IBUSY, DBUSY: if (bus.mem_ready) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        mem_req = 1'b0;
        if (state == IDLE) begin
            d_gnt = pick_d;
            i_gnt = bus.i_req & ~pick_d;
        end else begin
            mem_req = 1'b1;
        end
    end

    // Request fields are captured only on a grant, so they stay stable for the whole busy phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (d_gnt) begin
            we_q    <= bus.d_we;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_wdata;
            be_q    <= bus.d_be;
        end else if (i_gnt) begin
            we_q    <= 1'b0;
            addr_q  <= bus.i_addr;
            wdata_q <= '0;
            be_q    <= '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_valid_q <= (state == IBUSY) && bus.mem_ready;
            d_valid_q <= (state == DBUSY) && bus.mem_ready;
            if ((state == IBUSY) && bus.mem_ready) i_rdata_q <= bus.mem_rdata;
            if ((state == DBUSY) && bus.mem_ready) d_rdata_q <= bus.mem_rdata;
        end
    end

    assign bus.i_gnt     = i_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus arbitration and reset sequences.
// Build with +define+ARB_ROUND_ROBIN_EN to check the round-robin grant order.
module tb_mem_port_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        mr;
        logic [31:0] mrd;
        logic        eig;
        logic        edg;
        logic        emreq;
        logic [31:0] emaddr;
        logic        emwe;
        logic [31:0] emwd;
        logic [3:0]  embe;
        logic        eiv;
        logic        edv;
        logic [31:0] eird;
        logic [31:0] edrd;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] exp_q[$];

    function automatic vec_t mk(
        logic ir, logic [31:0] ia, logic dr, logic dwe, logic [31:0] da, logic [31:0] dwd,
        logic [3:0] dbe, logic mr, logic [31:0] mrd,
        logic eig, logic edg, logic emreq, logic [31:0] emaddr, logic emwe, logic [31:0] emwd,
        logic [3:0] embe, logic eiv, logic edv, logic [31:0] eird, logic [31:0] edrd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dwd = dwd; v.dbe = dbe;
        v.mr = mr; v.mrd = mrd;
        v.eig = eig; v.edg = edg; v.emreq = emreq; v.emaddr = emaddr; v.emwe = emwe;
        v.emwd = emwd; v.embe = embe; v.eiv = eiv; v.edv = edv; v.eird = eird; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        bus.i_req = v.ir; bus.i_addr = v.ia;
        bus.d_req = v.dr; bus.d_we = v.dwe; bus.d_addr = v.da; bus.d_wdata = v.dwd; bus.d_be = v.dbe;
        bus.mem_ready = v.mr; bus.mem_rdata = v.mrd;
        #1;
        tag = $sformatf("v%0d", idx);
        chk({tag, ".i_gnt"},     64'(bus.i_gnt),     64'(v.eig));
        chk({tag, ".d_gnt"},     64'(bus.d_gnt),     64'(v.edg));
        chk({tag, ".mem_req"},   64'(bus.mem_req),   64'(v.emreq));
        chk({tag, ".mem_addr"},  64'(bus.mem_addr),  64'(v.emaddr));
        chk({tag, ".mem_we"},    64'(bus.mem_we),    64'(v.emwe));
        chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(v.emwd));
        chk({tag, ".mem_be"},    64'(bus.mem_be),    64'(v.embe));
        chk({tag, ".i_valid"},   64'(bus.i_valid),   64'(v.eiv));
        chk({tag, ".d_valid"},   64'(bus.d_valid),   64'(v.edv));
        chk({tag, ".i_rdata"},   64'(bus.i_rdata),   64'(v.eird));
        chk({tag, ".d_rdata"},   64'(bus.d_rdata),   64'(v.edrd));
    endtask

    initial begin
        logic [31:0] prev_win;
        logic [31:0] win;
        drive_idle();

        // Reset values while rst_n is held low.
        #12;
        chk("rst.mem_req",  64'(bus.mem_req),  64'd0);
        chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst.mem_be",   64'(bus.mem_be),   64'd0);
        chk("rst.i_valid",  64'(bus.i_valid),  64'd0);
        chk("rst.d_rdata",  64'(bus.d_rdata),  64'd0);
        chk("rst.state",    64'(dbg_state),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, single fetch, held-off store, idle mem_ready pulse, back-to-back loads.
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,32'h100,0,0,0,0,0,0,0,                        1,0,0,0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h00500093,                   0,0,1,32'h100,0,0,4'hF,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,32'h2000,32'hDEADBEEF,4'h3,0,0,         0,1,0,32'h100,0,0,4'hF,1,0,32'h00500093,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,1,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,1,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,1,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h12345678,                   0,0,1,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,0,32'h2000,1,32'hDEADBEEF,4'h3,0,1,32'h00500093,32'h12345678));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'hAAAA5555,                   0,0,0,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,32'h12345678));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,0,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,32'h12345678));
        vecs.push_back(mk(0,0,1,0,32'h3000,0,4'hF,0,0,                    0,1,0,32'h2000,1,32'hDEADBEEF,4'h3,0,0,32'h00500093,32'h12345678));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h11111111,                   0,0,1,32'h3000,0,0,4'hF,0,0,32'h00500093,32'h12345678));
        vecs.push_back(mk(0,0,1,0,32'h3004,0,4'hF,0,0,                    0,1,0,32'h3000,0,0,4'hF,0,1,32'h00500093,32'h11111111));
        vecs.push_back(mk(0,0,0,0,0,0,0,1,32'h22222222,                   0,0,1,32'h3004,0,0,4'hF,0,0,32'h00500093,32'h11111111));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,0,32'h3004,0,0,4'hF,0,1,32'h00500093,32'h22222222));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,                              0,0,0,32'h3004,0,0,4'hF,0,0,32'h00500093,32'h22222222));
        foreach (vecs[k]) apply_vec(vecs[k], k);

        // Four transactions with both sides requesting; 0 = fetch wins, 1 = data wins.
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
`else
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
`endif
        prev_win = 32'hFFFF_FFFF;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            bus.i_req = 1'b1; bus.i_addr = 32'h400;
            bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h5000; bus.d_wdata = '0; bus.d_be = 4'hF;
            bus.mem_ready = 1'b0;
            #1;
            for (int w = 0; w < 5 && !(bus.i_gnt || bus.d_gnt); w++) begin
                @(negedge clk);
                #1;
            end
            if (prev_win != 32'hFFFF_FFFF) begin
                chk($sformatf("arb%0d.i_valid", t), 64'(bus.i_valid), 64'(prev_win == 32'd0));
                chk($sformatf("arb%0d.d_valid", t), 64'(bus.d_valid), 64'(prev_win == 32'd1));
            end
            chk($sformatf("arb%0d.one_gnt", t), 64'(bus.i_gnt ^ bus.d_gnt), 64'd1);
            win = bus.d_gnt ? 32'd1 : 32'd0;
            chk($sformatf("arb%0d.winner", t), 64'(win), 64'(exp_q[0]));
            @(negedge clk);
            bus.mem_ready = 1'b1; bus.mem_rdata = 32'h40 + 32'(t);
            #1;
            chk($sformatf("arb%0d.mem_addr", t), 64'(bus.mem_addr),
                (exp_q[0] == 32'd1) ? 64'h5000 : 64'h400);
            prev_win = exp_q.pop_front();
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("arb_last.d_valid", 64'(bus.d_valid), 64'(prev_win == 32'd1));
        chk("arb_last.i_valid", 64'(bus.i_valid), 64'(prev_win == 32'd0));

        // Reset while a load is in flight.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_addr = 32'h6000; bus.d_be = 4'hF;
        #1;
        chk("rmid.d_gnt", 64'(bus.d_gnt), 64'd1);
        @(negedge clk);
        bus.d_req = 1'b0;
        #1;
        chk("rmid.busy_mem_req", 64'(bus.mem_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid.mem_req_drop", 64'(bus.mem_req), 64'd0);
        chk("rmid.state",        64'(dbg_state),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            chk($sformatf("rmid.no_dvalid%0d", c), 64'(bus.d_valid), 64'd0);
        end

        // Normal fetch after reset release.
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h700;
        #1;
        chk("post.i_gnt", 64'(bus.i_gnt), 64'd1);
        @(negedge clk);
        bus.i_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        #1;
        chk("post.mem_addr", 64'(bus.mem_addr), 64'h700);
        @(negedge clk);
        drive_idle();
        #1;
        chk("post.i_valid", 64'(bus.i_valid), 64'd1);
        chk("post.i_rdata", 64'(bus.i_rdata), 64'hCAFEF00D);
        chk("post.d_valid", 64'(bus.d_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
